// File: rtl/fp_chk_pkg.sv
// Shared types and the tolerance compare for the forward-pass result checker.
package fp_chk_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, CHECK, DONE} chk_state_t;

    // Widest supported data path; narrower buses are sign-extended into it.
    localparam int MAX_W = 64;

    function automatic logic within_tol(
        input logic signed [MAX_W-1:0] act_v,
        input logic signed [MAX_W-1:0] exp_v,
        input logic        [MAX_W-1:0] tol_v
    );
        logic signed [MAX_W:0] diff;
        logic        [MAX_W:0] mag;
        diff = $signed({act_v[MAX_W-1], act_v}) - $signed({exp_v[MAX_W-1], exp_v});
        mag  = diff[MAX_W] ? $unsigned(-diff) : $unsigned(diff);
        return mag <= {1'b0, tol_v};
    endfunction

endpackage

// File: rtl/fp_argmax_tracker.sv
// Running argmax over a streamed burst; ties keep the lowest index.
module fp_argmax_tracker #(
    parameter int W     = 32,
    parameter int IDX_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                valid,
    input  logic [IDX_W-1:0]    idx,
    input  logic signed [W-1:0] val,
    output logic [IDX_W-1:0]    max_idx
);

    logic                have_q;
    logic signed [W-1:0] max_val_q;
    logic [IDX_W-1:0]    max_idx_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            have_q    <= 1'b0;
            max_val_q <= '0;
            max_idx_q <= '0;
        end else if (valid && (!have_q || val > max_val_q)) begin
            have_q    <= 1'b1;
            max_val_q <= val;
            max_idx_q <= idx;
        end
    end

    assign max_idx = max_idx_q;

endmodule

// File: rtl/fp_result_checker.sv
// Self-checker for the forward_pass_top result burst.
// Optional argmax comparison enabled by defining ARGMAX_CHECK_EN.
module fp_result_checker
    import fp_chk_pkg::*;
#(
    parameter int BUS_WIDTH   = 32,
    parameter int NUM_OUTPUTS = 10,
    parameter int TOL         = 0,
    localparam int IDX_W      = $clog2(NUM_OUTPUTS),
    localparam int CNT_W      = $clog2(NUM_OUTPUTS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        exp_wr_en,
    input  logic [IDX_W-1:0]            exp_wr_idx,
    input  logic signed [BUS_WIDTH-1:0] exp_wr_data,
    input  logic                        start,
    input  logic                        dut_done,
    input  logic signed [BUS_WIDTH-1:0] dut_out,
    output logic                        busy,
    output logic                        check_done,
    output logic                        pass,
    output logic                        fail,
    output logic [CNT_W-1:0]            err_count,
    output logic [IDX_W-1:0]            first_err_idx,
    output logic [BUS_WIDTH-1:0]        first_err_exp,
    output logic [BUS_WIDTH-1:0]        first_err_act
`ifdef ARGMAX_CHECK_EN
    ,
    output logic [IDX_W-1:0]            argmax_act,
    output logic [IDX_W-1:0]            argmax_exp,
    output logic                        argmax_ok
`endif
);

    localparam logic [31:0]      N_U    = 32'(NUM_OUTPUTS);
    localparam logic [CNT_W-1:0] ERR_MX = CNT_W'(NUM_OUTPUTS);
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(NUM_OUTPUTS - 1);

    logic signed [BUS_WIDTH-1:0] mem_q [NUM_OUTPUTS];

    chk_state_t                  state_q;
    logic [IDX_W-1:0]            idx_q;
    logic [CNT_W-1:0]            err_q;
    logic [IDX_W-1:0]            fe_idx_q;
    logic [BUS_WIDTH-1:0]        fe_exp_q;
    logic [BUS_WIDTH-1:0]        fe_act_q;
    logic                        cd_q;

    logic                        busy_w;
    logic                        start_acc;
    logic                        cmp_en;
    logic [IDX_W-1:0]            cmp_idx;
    logic signed [BUS_WIDTH-1:0] exp_cur;
    logic                        mism;
    logic                        am_match;
    logic                        in_done;

    assign busy_w    = (state_q == ARMED) || (state_q == CHECK);
    assign start_acc = start && !busy_w;
    assign cmp_en    = ((state_q == ARMED) && dut_done) || (state_q == CHECK);
    assign cmp_idx   = (state_q == CHECK) ? idx_q : '0;
    assign exp_cur   = mem_q[cmp_idx];
    assign mism      = cmp_en && !within_tol(MAX_W'(dut_out), MAX_W'(exp_cur),
                                             MAX_W'(TOL));
    assign in_done   = (state_q == DONE);

    // Expected memory keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (exp_wr_en && !busy_w && (32'(exp_wr_idx) < N_U)) begin
            mem_q[exp_wr_idx] <= exp_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            err_q    <= '0;
            fe_idx_q <= '0;
            fe_exp_q <= '0;
            fe_act_q <= '0;
            cd_q     <= 1'b0;
        end else begin
            cd_q <= 1'b0;
            if (mism && err_q != ERR_MX) begin
                err_q <= err_q + 1'b1;
                if (err_q == '0) begin
                    fe_idx_q <= cmp_idx;
                    fe_exp_q <= exp_cur;
                    fe_act_q <= dut_out;
                end
            end
            unique case (state_q)
                IDLE, DONE: begin
                    if (start_acc) begin
                        state_q  <= ARMED;
                        idx_q    <= '0;
                        err_q    <= '0;
                        fe_idx_q <= '0;
                        fe_exp_q <= '0;
                        fe_act_q <= '0;
                    end
                end
                ARMED: begin
                    if (dut_done) begin
                        state_q <= CHECK;
                        idx_q   <= IDX_W'(1);
                    end
                end
                CHECK: begin
                    if (idx_q == LAST) begin
                        state_q <= DONE;
                        cd_q    <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ARGMAX_CHECK_EN
    logic [IDX_W-1:0] am_act;
    logic [IDX_W-1:0] am_exp;

    fp_argmax_tracker #(.W(BUS_WIDTH), .IDX_W(IDX_W)) u_am_act (
        .clk(clk), .rst(rst), .clear(start_acc), .valid(cmp_en),
        .idx(cmp_idx), .val(dut_out), .max_idx(am_act)
    );

    fp_argmax_tracker #(.W(BUS_WIDTH), .IDX_W(IDX_W)) u_am_exp (
        .clk(clk), .rst(rst), .clear(start_acc), .valid(cmp_en),
        .idx(cmp_idx), .val(exp_cur), .max_idx(am_exp)
    );

    assign am_match   = (am_act == am_exp);
    assign argmax_act = am_act;
    assign argmax_exp = am_exp;
    assign argmax_ok  = in_done && am_match;
`else
    assign am_match = 1'b1;
`endif

    assign busy          = busy_w;
    assign check_done    = cd_q;
    assign pass          = in_done && (err_q == '0) && am_match;
    assign fail          = in_done && !((err_q == '0) && am_match);
    assign err_count     = err_q;
    assign first_err_idx = fe_idx_q;
    assign first_err_exp = fe_exp_q;
    assign first_err_act = fe_act_q;

endmodule

// File: tb/tb_fp_result_checker.sv
// Directed bench for fp_result_checker; two instances at TOL=0 and TOL=2.
// Argmax scenario compiled only when ARGMAX_CHECK_EN is defined.
module tb_fp_result_checker;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               exp_wr_en = 1'b0;
    logic [3:0]         exp_wr_idx = '0;
    logic signed [31:0] exp_wr_data = '0;
    logic               start = 1'b0;
    logic               dut_done = 1'b0;
    logic signed [31:0] dut_out = '0;

    logic        busy0, cd0, pass0, fail0;
    logic [3:0]  err0, fei0;
    logic [31:0] fee0, fea0;
    logic        busy2, cd2, pass2, fail2;
    logic [3:0]  err2, fei2;
    logic [31:0] fee2, fea2;
`ifdef ARGMAX_CHECK_EN
    logic [3:0]  ama0, ame0, ama2, ame2;
    logic        amok0, amok2;
`endif

    int checks = 0;
    int errors = 0;

    logic signed [31:0] ev [10];
    logic signed [31:0] av [10];

    always #5 clk = ~clk;

    fp_result_checker #(.BUS_WIDTH(32), .NUM_OUTPUTS(10), .TOL(0)) u0 (
        .clk(clk), .rst(rst), .exp_wr_en(exp_wr_en), .exp_wr_idx(exp_wr_idx),
        .exp_wr_data(exp_wr_data), .start(start), .dut_done(dut_done),
        .dut_out(dut_out), .busy(busy0), .check_done(cd0), .pass(pass0),
        .fail(fail0), .err_count(err0), .first_err_idx(fei0),
        .first_err_exp(fee0), .first_err_act(fea0)
`ifdef ARGMAX_CHECK_EN
        , .argmax_act(ama0), .argmax_exp(ame0), .argmax_ok(amok0)
`endif
    );

    fp_result_checker #(.BUS_WIDTH(32), .NUM_OUTPUTS(10), .TOL(2)) u2 (
        .clk(clk), .rst(rst), .exp_wr_en(exp_wr_en), .exp_wr_idx(exp_wr_idx),
        .exp_wr_data(exp_wr_data), .start(start), .dut_done(dut_done),
        .dut_out(dut_out), .busy(busy2), .check_done(cd2), .pass(pass2),
        .fail(fail2), .err_count(err2), .first_err_idx(fei2),
        .first_err_exp(fee2), .first_err_act(fea2)
`ifdef ARGMAX_CHECK_EN
        , .argmax_act(ama2), .argmax_exp(ame2), .argmax_ok(amok2)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic load_exp();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp_wr_en   = 1'b1;
            exp_wr_idx  = 4'(i);
            exp_wr_data = ev[i];
        end
        @(negedge clk);
        exp_wr_en = 1'b0;
    endtask

    task automatic arm();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    // Drives the burst; rst_at >= 0 asserts rst instead of that element.
    task automatic burst(input int rst_at, input bit intrude);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp_wr_en = 1'b0;
            start     = 1'b0;
            if (i == rst_at) begin
                rst      = 1'b1;
                dut_done = 1'b0;
                break;
            end
            dut_done = (i == 0);
            dut_out  = av[i];
            if (intrude && i == 2) begin
                exp_wr_en   = 1'b1;
                exp_wr_idx  = 4'd0;
                exp_wr_data = 32'sd999;
                start       = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_base();
        ev[0] = 5;   ev[1] = -3; ev[2] = 64; ev[3] = 0;  ev[4] = 100;
        ev[5] = -50; ev[6] = 7;  ev[7] = 7;  ev[8] = -1; ev[9] = 20;
        for (int i = 0; i < 10; i++) av[i] = ev[i];
    endtask

    initial begin
        set_base();
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy0, 0);
        check("rst_cd", cd0, 0);
        check("rst_pass", pass0, 0);
        check("rst_fail", fail0, 0);
        check("rst_err", err0, 0);
        check("rst_fe", {fei0, fee0, fea0}, 0);
        @(negedge clk);
        rst = 1'b0;

        // T1: exact burst; last expected written in the start cycle
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            exp_wr_en = 1'b1; exp_wr_idx = 4'(i); exp_wr_data = ev[i];
        end
        @(negedge clk);
        exp_wr_en = 1'b1; exp_wr_idx = 4'd9; exp_wr_data = ev[9]; start = 1'b1;
        @(negedge clk);
        exp_wr_en = 1'b0; start = 1'b0;
        check("t1_busy", busy0, 1);
        repeat (3) @(negedge clk);
        check("t1_armed_wait", {busy0, cd0}, 2'b10);
        burst(-1, 0);
        check("t1_cd", cd0, 1);
        check("t1_pass", {pass0, fail0}, 2'b10);
        check("t1_err", err0, 0);
        check("t1_pass2", pass2, 1);
        @(posedge clk); #1;
        check("t1_cd_pulse", cd0, 0);
        check("t1_hold", {pass0, busy0}, 2'b10);

        // T2: element 7 off by +2
        av[7] = 9;
        arm();
        check("t2_cleared", {pass0, fail0}, 0);
        burst(-1, 0);
        check("t2_fail0", {pass0, fail0}, 2'b01);
        check("t2_err0", err0, 1);
        check("t2_idx0", fei0, 7);
        check("t2_exp0", fee0, 7);
        check("t2_act0", fea0, 9);
        check("t2_pass2", {pass2, err2}, {1'b1, 4'd0});

        // T3: +2/-2 on elements 1 and 4, then -3 on element 4
        set_base();
        av[1] = -1; av[4] = 98;
        arm();
        burst(-1, 0);
        check("t3_pass2", {pass2, fail2, err2}, {2'b10, 4'd0});
        check("t3_err0", {err0, fei0}, {4'd2, 4'd1});
        av[4] = 97;
        arm();
        burst(-1, 0);
        check("t3_err2", {fail2, err2, fei2}, {1'b1, 4'd1, 4'd4});
        check("t3_fe2", {fee2, fea2}, {32'd100, 32'd97});

        // T4: intrusions mid-CHECK, then reset at element 5
        for (int i = 0; i < 10; i++) av[i] = ev[i] + 5;
        arm();
        burst(5, 1);
        check("t4_idle", {busy0, cd0, pass0, fail0}, 0);
        check("t4_clr", {err0, fei0, fee0, fea0}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("t4_no_cd", {cd0, busy0}, 0);
        set_base();
        arm();
        burst(-1, 0);
        check("t4_wr_dropped", {pass0, err0}, {1'b1, 4'd0});

        // T5: extreme values do not wrap; every element wrong
        for (int i = 0; i < 10; i++) begin
            ev[i] = 32'sh7FFF_FFFF;
            av[i] = 32'sh8000_0000;
        end
        load_exp();
        arm();
        burst(-1, 0);
        check("t5_err0", {fail0, err0}, {1'b1, 4'd10});
        check("t5_err2", {fail2, err2, fei2}, {1'b1, 4'd10, 4'd0});
        check("t5_fe2", {fee2, fea2}, {32'h7FFF_FFFF, 32'h8000_0000});

`ifdef ARGMAX_CHECK_EN
        // T6: values within tolerance but argmax differs
        for (int i = 0; i < 10; i++) begin
            ev[i] = 32'(i % 3);
            av[i] = ev[i];
        end
        ev[2] = 48; ev[3] = 50; ev[6] = 48;
        av[2] = 49; av[3] = 48; av[6] = 49;
        load_exp();
        arm();
        burst(-1, 0);
        check("t6_err2", err2, 0);
        check("t6_am", {ama2, ame2}, {4'd2, 4'd3});
        check("t6_fail2", {pass2, fail2, amok2}, 3'b010);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
